// File: rtl/int_mul_hs_responder.sv
// Callee side of the ap_ctrl_hs start/ready/done handshake wrapped around a
// radix-2 shift-add unsigned multiplier; the result is scrambled unless working_key matches LOCK_KEY.
module int_mul_hs_responder #(
    parameter int             WIDTH    = 32,
    parameter logic [255:0]   LOCK_KEY = 256'h0
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_ready,
    output logic                 ap_done,
    output logic                 ap_idle,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   ap_return,
    input  logic [255:0]         working_key
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_CALC = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_acc;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_return;
    logic [PW-1:0]     w_acc_nxt;
    logic              w_last;
    logic              w_key_ok;

    function automatic logic key_match(input logic [255:0] key);
        return (key == LOCK_KEY);
    endfunction

    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last    = (r_count == LAST_CNT);
    assign w_key_ok  = key_match(working_key);
    assign ap_return = r_return;

    // State register; reset aborts any operation in flight without a done pulse
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; any illegal encoding recovers to IDLE
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (ap_start) begin
                    w_state_nxt = S_CALC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_CALC;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the one-hot state
    always_comb begin
        ap_ready = 1'b0;
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                ap_ready = ap_start;
                ap_idle  = ~ap_start;
            end
            S_CALC: begin
                ap_ready = 1'b0;
            end
            S_DONE: begin
                ap_done = 1'b1;
            end
            default: begin
                ap_ready = 1'b0;
            end
        endcase
    end

    // Shift-add datapath; the result register is loaded on the last CALC edge
    // so it is already valid in the DONE cycle, and holds until the next op.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_mcand  <= {PW{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_acc    <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_return <= {PW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, a};
                        r_mplier <= b;
                        r_acc    <= {PW{1'b0}};
                        r_count  <= {CW{1'b0}};
                    end
                end
                S_CALC: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (w_last) begin
                        r_return <= w_key_ok ? w_acc_nxt : ~w_acc_nxt;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_mul_hs_responder.sv
// Self-checking bench for int_mul_hs_responder: directed handshake scenarios
// plus randomized operations compared against an arithmetic reference model.
module tb_int_mul_hs_responder;

    localparam int           WIDTH = 32;
    localparam logic [255:0] KEY   = 256'hC0FFEE00_DEADBEEF_12345678_9ABCDEF0_0F1E2D3C_4B5A6978_87654321_A5A5A5A5;

    logic                ap_clk;
    logic                ap_rst;
    logic                ap_start;
    logic                ap_ready;
    logic                ap_done;
    logic                ap_idle;
    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [2*WIDTH-1:0]  ap_return;
    logic [255:0]        working_key;

    int errors = 0;
    int checks = 0;

    int_mul_hs_responder #(.WIDTH(WIDTH), .LOCK_KEY(KEY)) dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_idle     (ap_idle),
        .a           (a),
        .b           (b),
        .ap_return   (ap_return),
        .working_key (working_key)
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic [255:0] key);
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        return (key == KEY) ? p : ~p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Runs cycles after an accept until ap_done (bounded); cyc is the cycle index
    task automatic wait_done(input bit hold, input bit scramble, input bit pulse,
                             output int cyc, output int readies);
        cyc = -1;
        readies = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (scramble) begin
                a = $urandom;
                b = $urandom;
            end
            if (pulse) ap_start = (c < WIDTH) ? c[0] : 1'b0;
            else if (!hold) ap_start = 1'b0;
            #1;
            if (ap_ready) readies++;
            if (ap_done) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic single_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic [255:0] key, input bit scramble, input bit pulse);
        int cyc;
        int rdy;
        logic [63:0] exp;
        exp = model(x, y, key);
        a = x;
        b = y;
        working_key = key;
        ap_start = 1'b1;
        #1;
        chk({tag, "_ready_c0"}, 64'(ap_ready), 64'd1);
        wait_done(1'b0, scramble, pulse, cyc, rdy);
        chk({tag, "_done_cycle"}, 64'(cyc), 64'(WIDTH + 1));
        chk({tag, "_calc_ready"}, 64'(rdy), 64'd0);
        chk({tag, "_return"}, ap_return, exp);
        ap_start = 1'b0;
        tick();
        chk({tag, "_done_drop"}, 64'(ap_done), 64'd0);
        chk({tag, "_return_hold"}, ap_return, exp);
    endtask

    initial begin
        int cyc;
        int rdy;
        int dones;
        logic [31:0]  rx;
        logic [31:0]  ry;
        logic [255:0] rk;

        ap_rst = 1'b1;
        ap_start = 1'b0;
        a = '0;
        b = '0;
        working_key = KEY;
        #3;
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_ready", 64'(ap_ready), 64'd0);
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_return", ap_return, 64'd0);
        tick();
        tick();
        ap_rst = 1'b0;
        tick();

        // basic op
        single_op("basic", 32'd7, 32'd9, KEY, 1'b0, 1'b0);

        // asynchronous reset mid-CALC, between clock edges
        a = 32'd7;
        b = 32'd9;
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #3;
        ap_rst = 1'b1;
        #1;
        chk("arst_idle", 64'(ap_idle), 64'd1);
        chk("arst_return", ap_return, 64'd0);
        chk("arst_done", 64'(ap_done), 64'd0);
        tick();
        ap_rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ap_done) dones++;
        end
        chk("arst_no_done", 64'(dones), 64'd0);
        chk("arst_idle_after", 64'(ap_idle), 64'd1);

        // extremes
        single_op("max", 32'hFFFFFFFF, 32'hFFFFFFFF, KEY, 1'b0, 1'b0);
        chk("max_value", ap_return, 64'hFFFFFFFE00000001);
        single_op("zero", 32'd0, 32'h12345678, KEY, 1'b0, 1'b0);

        // back-to-back with ap_start held continuously
        a = 32'd3;
        b = 32'd5;
        ap_start = 1'b1;
        #1;
        chk("b2b_ready0", 64'(ap_ready), 64'd1);
        wait_done(1'b1, 1'b0, 1'b0, cyc, rdy);
        chk("b2b_done1_cycle", 64'(cyc), 64'(WIDTH + 1));
        chk("b2b_ready_in_calc", 64'(rdy), 64'd0);
        chk("b2b_ret1", ap_return, 64'd15);
        a = 32'd100000;
        b = 32'd100000;
        tick();
        chk("b2b_ready1", 64'(ap_ready), 64'd1);
        chk("b2b_done_single", 64'(ap_done), 64'd0);
        wait_done(1'b0, 1'b0, 1'b0, cyc, rdy);
        chk("b2b_done2_cycle", 64'(cyc), 64'(WIDTH + 1));
        chk("b2b_ret2", ap_return, 64'd10000000000);
        tick();
        chk("b2b_done2_drop", 64'(ap_done), 64'd0);

        // operand hold and ignored starts during CALC
        single_op("hold", 32'd6, 32'd7, KEY, 1'b1, 1'b1);

        // lock
        single_op("lock_bad", 32'd2, 32'd3, KEY ^ 256'h1, 1'b0, 1'b0);
        chk("lock_bad_value", ap_return, 64'hFFFFFFFFFFFFFFF9);
        single_op("lock_good", 32'd2, 32'd3, KEY, 1'b0, 1'b0);

        // randomized operations against the reference model
        for (int i = 0; i < 10; i++) begin
            rx = $urandom;
            ry = $urandom;
            if (i == 3) ry = 32'd1;
            rk = ($urandom_range(0, 3) == 0) ? (KEY ^ (256'h1 << $urandom_range(0, 255))) : KEY;
            single_op("rand", rx, ry, rk, 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
